// File: rtl/eth_frame_recv.sv
// Ethernet LocalLink receiver: header parse, MAC/EtherType filter, payload packed low-byte-first into 32-bit words.
// Optional RX_STATS_EN adds saturating good/drop frame counters.
module eth_frame_recv #(
    parameter logic [47:0] LOCAL_MAC   = 48'hda0203040506,
    parameter logic [15:0] ETH_TYPE    = 16'h0800,
    parameter int unsigned MAX_PAYLOAD = 1420
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        sof,
    input  logic        eof,
    input  logic        src_rdy,
    output logic        dst_rdy,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_last,
    output logic [2:0]  word_bytes,
    output logic        frame_done,
    output logic        frame_good
`ifdef RX_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, DROP} state_e;

    localparam logic [10:0] MAX_P  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MAX_P1 = 11'(MAX_PAYLOAD + 1);

    state_e      state_q, state_d;
    logic [3:0]  hdr_cnt_q, hdr_cnt_d;
    logic        local_ok_q, local_ok_d;
    logic        bcast_ok_q, bcast_ok_d;
    logic        type_ok_q, type_ok_d;
    logic [31:0] acc_q, acc_d;
    logic [2:0]  acc_cnt_q, acc_cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] word_out_q, word_out_d;
    logic        word_valid_q, word_valid_d;
    logic        word_last_q, word_last_d;
    logic [2:0]  word_bytes_q, word_bytes_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_good_q, frame_good_d;

    logic        beat;
    logic        stored;
    logic        pass;
    logic [31:0] acc_ins;

    function automatic logic [7:0] mac_byte(input logic [3:0] idx);
        logic [47:0] sh;
        sh = LOCAL_MAC << {idx, 3'b000};
        return sh[47:40];
    endfunction

    assign dst_rdy = ~word_valid_q | word_ready;
    assign beat    = src_rdy & dst_rdy;

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        local_ok_d   = local_ok_q;
        bcast_ok_d   = bcast_ok_q;
        type_ok_d    = type_ok_q;
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        word_last_d  = word_last_q;
        word_bytes_d = word_bytes_q;
        frame_done_d = 1'b0;
        frame_good_d = 1'b0;

        stored  = byte_cnt_q < MAX_P;
        acc_ins = acc_q | ({24'd0, data_in} << {acc_cnt_q[1:0], 3'b000});
        pass    = (local_ok_q | bcast_ok_q) & type_ok_q & (data_in == ETH_TYPE[7:0]);

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        if (beat) begin
            if (sof) begin
                frame_done_d = (state_q != IDLE) | eof;
                acc_d        = '0;
                acc_cnt_d    = '0;
                byte_cnt_d   = '0;
                local_ok_d   = (data_in == LOCAL_MAC[47:40]);
                bcast_ok_d   = (data_in == 8'hff);
                type_ok_d    = 1'b1;
                hdr_cnt_d    = 4'd1;
                state_d      = eof ? IDLE : HEAD;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    HEAD: begin
                        hdr_cnt_d = hdr_cnt_q + 4'd1;
                        if (hdr_cnt_q < 4'd6) begin
                            local_ok_d = local_ok_q & (data_in == mac_byte(hdr_cnt_q));
                            bcast_ok_d = bcast_ok_q & (data_in == 8'hff);
                        end
                        if (hdr_cnt_q == 4'd12) begin
                            type_ok_d = type_ok_q & (data_in == ETH_TYPE[15:8]);
                        end
                        if (hdr_cnt_q == 4'd13) begin
                            if (eof) begin
                                frame_done_d = 1'b1;
                                frame_good_d = pass;
                                state_d      = IDLE;
                            end else begin
                                state_d = pass ? PAYLOAD : DROP;
                            end
                        end else if (eof) begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end
                    end
                    PAYLOAD: begin
                        if (stored) begin
                            acc_d      = acc_ins;
                            acc_cnt_d  = acc_cnt_q + 3'd1;
                            byte_cnt_d = byte_cnt_q + 11'd1;
                        end else begin
                            byte_cnt_d = MAX_P1;
                        end
                        // The word completed by the last in-limit byte is held back so an
                        // overflowing frame can still mark its last stored word.
                        if (eof) begin
                            if (acc_cnt_d != 3'd0) begin
                                word_out_d   = acc_d;
                                word_valid_d = 1'b1;
                                word_last_d  = 1'b1;
                                word_bytes_d = acc_cnt_d;
                            end
                            frame_done_d = 1'b1;
                            frame_good_d = stored;
                            acc_d        = '0;
                            acc_cnt_d    = '0;
                            state_d      = IDLE;
                        end else if (stored && acc_cnt_q == 3'd3 && (byte_cnt_q + 11'd1) < MAX_P) begin
                            word_out_d   = acc_ins;
                            word_valid_d = 1'b1;
                            word_last_d  = 1'b0;
                            word_bytes_d = 3'd4;
                            acc_d        = '0;
                            acc_cnt_d    = '0;
                        end
                    end
                    DROP: begin
                        if (eof) begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hdr_cnt_q    <= '0;
            local_ok_q   <= 1'b0;
            bcast_ok_q   <= 1'b0;
            type_ok_q    <= 1'b0;
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            word_bytes_q <= '0;
            frame_done_q <= 1'b0;
            frame_good_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            local_ok_q   <= local_ok_d;
            bcast_ok_q   <= bcast_ok_d;
            type_ok_q    <= type_ok_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            word_last_q  <= word_last_d;
            word_bytes_q <= word_bytes_d;
            frame_done_q <= frame_done_d;
            frame_good_q <= frame_good_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_last  = word_last_q;
    assign word_bytes = word_bytes_q;
    assign frame_done = frame_done_q;
    assign frame_good = frame_good_q;

`ifdef RX_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        good_cnt_d = good_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (frame_done_q) begin
            if (frame_good_q && good_cnt_q != 16'hffff) good_cnt_d = good_cnt_q + 16'd1;
            if (!frame_good_q && drop_cnt_q != 16'hffff) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign good_cnt = good_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_eth_frame_recv.sv
// Directed self-checking bench for eth_frame_recv; inputs change 1 time unit after posedge, outputs observed at negedge.
module tb_eth_frame_recv;

    localparam logic [47:0] LOCAL   = 48'hda0203040506;
    localparam logic [47:0] SRC_MAC = 48'h002b67beceaa;
    localparam logic [47:0] BCAST   = 48'hffffffffffff;
    localparam logic [47:0] BAD_MAC = 48'h112233445566;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = '0;
    logic        sof = 1'b0, eof = 1'b0, src_rdy = 1'b0;
    logic        word_ready = 1'b1;
    logic        dst_rdy, word_valid, word_last, frame_done, frame_good;
    logic [31:0] word_out;
    logic [2:0]  word_bytes;
`ifdef RX_STATS_EN
    logic [15:0] good_cnt, drop_cnt;
`endif

    eth_frame_recv dut (
        .clk(clk), .rst(rst), .data_in(data_in), .sof(sof), .eof(eof),
        .src_rdy(src_rdy), .dst_rdy(dst_rdy), .word_out(word_out),
        .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last),
        .word_bytes(word_bytes), .frame_done(frame_done), .frame_good(frame_good)
`ifdef RX_STATS_EN
        , .good_cnt(good_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stall_cycles = 0;
    logic [31:0] wq[$];
    logic        wl[$];
    logic [2:0]  wb[$];
    logic        dq[$];
    logic [9:0]  tx[$];

    always @(negedge clk) begin
        if (word_valid && word_ready) begin
            wq.push_back(word_out);
            wl.push_back(word_last);
            wb.push_back(word_bytes);
        end
        if (frame_done) dq.push_back(frame_good);
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hdr(input logic [47:0] mac, input logic [15:0] typ, input logic last);
        logic [7:0] b;
        for (int i = 0; i < 14; i++) begin
            if (i < 6)       b = mac[47 - 8*i -: 8];
            else if (i < 12) b = SRC_MAC[47 - 8*(i-6) -: 8];
            else if (i == 12) b = typ[15:8];
            else             b = typ[7:0];
            tx.push_back({i == 0, last && i == 13, b});
        end
    endtask

    task automatic push_pay(input int n, input logic last);
        for (int i = 0; i < n; i++) tx.push_back({1'b0, last && i == n-1, 8'(i + 1)});
    endtask

    task automatic send_all();
        int guard;
        while (tx.size() > 0) begin
            {sof, eof, data_in} = tx.pop_front();
            src_rdy = 1'b1;
            guard = 0;
            #3;
            while (!dst_rdy && guard < 200) begin
                stall_cycles++;
                @(posedge clk);
                #3;
                guard++;
            end
            if (guard >= 200) begin
                tests++;
                fails++;
                $error("FAIL send_timeout: dst_rdy stayed 0 for %0d cycles, required 1", guard);
            end
            @(posedge clk);
            #1;
        end
        src_rdy = 1'b0;
        sof = 1'b0;
        eof = 1'b0;
    endtask

    task automatic drain();
        repeat (4) step();
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic last, input logic [2:0] nb);
        if (wq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed no word, expected %h", tag, w);
        end else begin
            check(tag, {4'd0, wq.pop_front(), wl.pop_front(), wb.pop_front()}, {4'd0, w, last, nb});
        end
    endtask

    task automatic expect_done(input string tag, input logic good);
        if (dq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed no frame_done, expected good=%0d", tag, good);
        end else begin
            check(tag, 40'(dq.pop_front()), 40'(good));
        end
    endtask

    task automatic expect_empty(input string tag);
        check({tag, "_words"}, 40'(wq.size()), 40'd0);
        check({tag, "_dones"}, 40'(dq.size()), 40'd0);
    endtask

    task automatic expect_long(input string tag, input logic [31:0] last_w);
        int n, nlast;
        logic [31:0] w0, wz;
        logic lz;
        logic [2:0] bz;
        n = wq.size();
        nlast = 0;
        w0 = (n > 0) ? wq[0] : 32'hx;
        wz = 'x; lz = 'x; bz = 'x;
        while (wq.size() > 0) begin
            wz = wq.pop_front();
            lz = wl.pop_front();
            bz = wb.pop_front();
            if (lz) nlast++;
        end
        check({tag, "_count"}, 40'(n), 40'd355);
        check({tag, "_first"}, 40'(w0), 40'h04030201);
        check({tag, "_final"}, {4'd0, wz, lz, bz}, {4'd0, last_w, 1'b1, 3'd4});
        check({tag, "_nlast"}, 40'(nlast), 40'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("rst_dst_rdy",    40'(dst_rdy),    40'd1);
        check("rst_word_valid", 40'(word_valid), 40'd0);
        check("rst_word_out",   40'(word_out),   40'd0);
        check("rst_last_bytes", {36'd0, word_last, word_bytes}, 40'd0);
        check("rst_done_good",  {38'd0, frame_done, frame_good}, 40'd0);
        rst = 1'b0;
        step();

        push_hdr(LOCAL, 16'h0800, 1'b0); push_pay(8, 1'b1); send_all(); drain();
        expect_word("p8_w0", 32'h04030201, 1'b0, 3'd4);
        expect_word("p8_w1", 32'h08070605, 1'b1, 3'd4);
        expect_done("p8_done", 1'b1);
        expect_empty("p8");

        push_hdr(LOCAL, 16'h0800, 1'b0); push_pay(5, 1'b1); send_all(); drain();
        expect_word("p5_w0", 32'h04030201, 1'b0, 3'd4);
        expect_word("p5_w1", 32'h00000005, 1'b1, 3'd1);
        expect_done("p5_done", 1'b1);

        stall_cycles = 0;
        push_hdr(BAD_MAC, 16'h0800, 1'b0); push_pay(4, 1'b1); send_all(); drain();
        check("badmac_stalls", 40'(stall_cycles), 40'd0);
        expect_done("badmac_done", 1'b0);
        expect_empty("badmac");
        push_hdr(LOCAL, 16'h0806, 1'b0); push_pay(4, 1'b1); send_all(); drain();
        check("badtype_stalls", 40'(stall_cycles), 40'd0);
        expect_done("badtype_done", 1'b0);
        expect_empty("badtype");

        push_hdr(LOCAL, 16'h0800, 1'b0); push_pay(12, 1'b1);
        fork
            send_all();
            begin
                int g;
                g = 0;
                while (!word_valid && g < 200) begin step(); g++; end
                word_ready = 1'b0;
                step();
                check("bp_dst_rdy_low", {38'd0, dst_rdy, word_valid}, 40'b01);
                repeat (9) step();
                word_ready = 1'b1;
            end
        join
        drain();
        check("bp_stalled", 40'(stall_cycles > 0), 40'd1);
        expect_word("bp_w0", 32'h04030201, 1'b0, 3'd4);
        expect_word("bp_w1", 32'h08070605, 1'b0, 3'd4);
        expect_word("bp_w2", 32'h0c0b0a09, 1'b1, 3'd4);
        expect_done("bp_done", 1'b1);

        push_hdr(LOCAL, 16'h0800, 1'b0); push_pay(2, 1'b0);
        push_hdr(LOCAL, 16'h0800, 1'b0); push_pay(4, 1'b1); send_all(); drain();
        expect_done("abort_a_done", 1'b0);
        expect_word("abort_b_w0", 32'h04030201, 1'b1, 3'd4);
        expect_done("abort_b_done", 1'b1);
        expect_empty("abort");

        push_hdr(BCAST, 16'h0800, 1'b0); push_pay(3, 1'b1); send_all(); drain();
        expect_word("bcast_w0", 32'h00030201, 1'b1, 3'd3);
        expect_done("bcast_done", 1'b1);

        push_hdr(LOCAL, 16'h0800, 1'b1); send_all(); drain();
        expect_done("zero_done", 1'b1);
        expect_empty("zero");

        tx.push_back({1'b1, 1'b1, 8'hda}); send_all(); drain();
        expect_done("runt1_done", 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [47:0] m;
            m = LOCAL;
            tx.push_back({i == 0, i == 5, m[47 - 8*i -: 8]});
        end
        send_all(); drain();
        expect_done("runt6_done", 1'b0);
        expect_empty("runt");

`ifdef RX_STATS_EN
        check("stats_good", 40'(good_cnt), 40'd6);
        check("stats_drop", 40'(drop_cnt), 40'd5);
`endif

        push_hdr(LOCAL, 16'h0800, 1'b0); push_pay(2, 1'b0); send_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_pay(6, 1'b1); send_all(); drain();
        expect_empty("midrst");

        push_hdr(LOCAL, 16'h0800, 1'b0); push_pay(1420, 1'b1); send_all(); drain();
        expect_long("max", 32'h8c8b8a89);
        expect_done("max_done", 1'b1);

        push_hdr(LOCAL, 16'h0800, 1'b0); push_pay(1425, 1'b1); send_all(); drain();
        expect_long("ovf", 32'h8c8b8a89);
        expect_done("ovf_done", 1'b0);
        expect_empty("ovf");

`ifdef RX_STATS_EN
        check("stats_good_post", 40'(good_cnt), 40'd1);
        check("stats_drop_post", 40'(drop_cnt), 40'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
